// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps a synthesizer frequency word from f_start to f_stop.
// At each point it waits for the core to settle, then integrates the core's
// I/Q samples. It presents one result per point on a valid/ready stream.
// Optional magnitude output: define FREQ_SWEEP_MAG_EN to build res_mag = |I|+|Q|.
// Without that macro, res_mag is tied to zero.
module freq_sweep_ctrl #(
   parameter int FREQ_W = 14,
   parameter int DATA_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             abort,
   input  logic [FREQ_W-1:0]                f_start,
   input  logic [FREQ_W-1:0]                f_stop,
   input  logic [FREQ_W-1:0]                f_step,
   input  logic [CNT_W-1:0]                 settle_cyc,
   input  logic [CNT_W-1:0]                 meas_cyc,
   output logic [FREQ_W-1:0]                freq,
   output logic                             ctrl,
   input  logic signed [DATA_W-1:0]         i_in,
   input  logic signed [DATA_W-1:0]         q_in,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [FREQ_W-1:0]                res_freq,
   output logic signed [DATA_W+CNT_W-1:0]   res_i,
   output logic signed [DATA_W+CNT_W-1:0]   res_q,
   output logic [DATA_W+CNT_W:0]            res_mag,
   output logic                             busy,
   output logic                             done
);

   localparam int ACC_W = DATA_W + CNT_W;

   typedef enum logic [1:0] {IDLE, SETTLE, MEAS, OUT} state_t;

   state_t                   state_q, state_d;
   logic [FREQ_W-1:0]        freq_q, freq_d;
   logic                     ctrl_q, ctrl_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [FREQ_W-1:0]        f_stop_q, f_stop_d;
   logic [FREQ_W-1:0]        f_step_q, f_step_d;
   logic [CNT_W-1:0]         settle_q, settle_d;
   logic [CNT_W-1:0]         meas_q, meas_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
   logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
   logic                     res_valid_q, res_valid_d;
   logic [FREQ_W-1:0]        res_freq_q, res_freq_d;
   logic signed [ACC_W-1:0]  res_i_q, res_i_d;
   logic signed [ACC_W-1:0]  res_q_q, res_q_d;

   // Accumulator values including the current sample; in the last
   // measurement cycle these become the result.
   logic signed [ACC_W-1:0]  sum_i, sum_q;
   assign sum_i = acc_i_q + $signed({{CNT_W{i_in[DATA_W-1]}}, i_in});
   assign sum_q = acc_q_q + $signed({{CNT_W{q_in[DATA_W-1]}}, q_in});

   // Dwell lengths of zero behave as one cycle.
   logic [CNT_W-1:0] settle_last, meas_last;
   assign settle_last = (settle_q == '0) ? '0 : settle_q - 1'b1;
   assign meas_last   = (meas_q   == '0) ? '0 : meas_q   - 1'b1;

   // The extra bit catches a step that runs past the top of the frequency range.
   logic [FREQ_W:0] freq_sum;
   logic            sweep_end;
   assign freq_sum  = {1'b0, freq_q} + {1'b0, f_step_q};
   assign sweep_end = (f_step_q == '0) || freq_sum[FREQ_W] ||
                      (freq_sum[FREQ_W-1:0] > f_stop_q);

`ifdef FREQ_SWEEP_MAG_EN
   logic [ACC_W:0]   res_mag_q, res_mag_d;
   logic [ACC_W-1:0] abs_i, abs_q;
   logic [ACC_W:0]   mag_sum;
   // The magnitude of the most negative sum still fits as an unsigned ACC_W value.
   assign abs_i   = sum_i[ACC_W-1] ? $unsigned(-sum_i) : $unsigned(sum_i);
   assign abs_q   = sum_q[ACC_W-1] ? $unsigned(-sum_q) : $unsigned(sum_q);
   assign mag_sum = {1'b0, abs_i} + {1'b0, abs_q};
   assign res_mag = res_mag_q;
`else
   assign res_mag = '0;
`endif

   // Next-state and output decode for the sweep sequencer.
   always_comb begin
      state_d     = state_q;
      freq_d      = freq_q;
      ctrl_d      = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      f_stop_d    = f_stop_q;
      f_step_d    = f_step_q;
      settle_d    = settle_q;
      meas_d      = meas_q;
      cnt_d       = cnt_q;
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      res_valid_d = res_valid_q;
      res_freq_d  = res_freq_q;
      res_i_d     = res_i_q;
      res_q_d     = res_q_q;
`ifdef FREQ_SWEEP_MAG_EN
      res_mag_d   = res_mag_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d  = SETTLE;
               freq_d   = f_start;
               ctrl_d   = 1'b1;
               busy_d   = 1'b1;
               cnt_d    = '0;
               f_stop_d = f_stop;
               f_step_d = f_step;
               settle_d = settle_cyc;
               meas_d   = meas_cyc;
            end
         end
         SETTLE: begin
            if (cnt_q == settle_last) begin
               state_d = MEAS;
               cnt_d   = '0;
               acc_i_d = '0;
               acc_q_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         MEAS: begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            if (cnt_q == meas_last) begin
               state_d     = OUT;
               cnt_d       = '0;
               res_valid_d = 1'b1;
               res_freq_d  = freq_q;
               res_i_d     = sum_i;
               res_q_d     = sum_q;
`ifdef FREQ_SWEEP_MAG_EN
               res_mag_d   = mag_sum;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (sweep_end) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = SETTLE;
                  freq_d  = freq_sum[FREQ_W-1:0];
                  ctrl_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort beats everything else; the frequency word is left where it was.
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         freq_d      = freq_q;
         ctrl_d      = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         res_valid_d = 1'b0;
         cnt_d       = '0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         freq_q      <= '0;
         ctrl_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         f_stop_q    <= '0;
         f_step_q    <= '0;
         settle_q    <= '0;
         meas_q      <= '0;
         cnt_q       <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         res_valid_q <= 1'b0;
         res_freq_q  <= '0;
         res_i_q     <= '0;
         res_q_q     <= '0;
`ifdef FREQ_SWEEP_MAG_EN
         res_mag_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         freq_q      <= freq_d;
         ctrl_q      <= ctrl_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         f_stop_q    <= f_stop_d;
         f_step_q    <= f_step_d;
         settle_q    <= settle_d;
         meas_q      <= meas_d;
         cnt_q       <= cnt_d;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         res_valid_q <= res_valid_d;
         res_freq_q  <= res_freq_d;
         res_i_q     <= res_i_d;
         res_q_q     <= res_q_d;
`ifdef FREQ_SWEEP_MAG_EN
         res_mag_q   <= res_mag_d;
`endif
      end
   end

   assign freq      = freq_q;
   assign ctrl      = ctrl_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign res_valid = res_valid_q;
   assign res_freq  = res_freq_q;
   assign res_i     = res_i_q;
   assign res_q     = res_q_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Testbench for freq_sweep_ctrl. A reference model builds the expected
// frequency list for each sweep and sums the I/Q samples driven during
// each measurement window. The bench checks the frequency word, ctrl,
// busy, done and the result stream against that model.
module tb_freq_sweep_ctrl;
   localparam int FREQ_W = 14;
   localparam int DATA_W = 10;
   localparam int CNT_W  = 16;
   localparam int ACC_W  = DATA_W + CNT_W;
   localparam int FMAX   = (1 << FREQ_W) - 1;

   logic                     clk;
   logic                     rst, start, abort;
   logic [FREQ_W-1:0]        f_start, f_stop, f_step;
   logic [CNT_W-1:0]         settle_cyc, meas_cyc;
   logic [FREQ_W-1:0]        freq;
   logic                     ctrl;
   logic signed [DATA_W-1:0] i_in, q_in;
   logic                     res_valid, res_ready;
   logic [FREQ_W-1:0]        res_freq;
   logic signed [ACC_W-1:0]  res_i, res_q;
   logic [ACC_W:0]           res_mag;
   logic                     busy, done;

   int n_vec = 0;
   int n_err = 0;

   freq_sweep_ctrl #(.FREQ_W(FREQ_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
      .settle_cyc(settle_cyc), .meas_cyc(meas_cyc),
      .freq(freq), .ctrl(ctrl), .i_in(i_in), .q_in(q_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_freq(res_freq),
      .res_i(res_i), .res_q(res_q), .res_mag(res_mag),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it and report any difference.
   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint abs64(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   // Run one sweep: fs/fe/fst are the bounds and step, and s/m are the
   // settle and measure lengths. stall is the number of not-ready cycles
   // in OUT (negative picks a random count). cst drives I=5 and Q=-3.
   // abort_pt is the point index whose measurement is aborted (-1 = none).
   task automatic run_sweep(input int fs, input int fe, input int fst,
                            input int s, input int m, input int stall,
                            input bit cst, input int abort_pt);
      int     freqs[$];
      int     f, nxt, sn, mn, ns;
      longint si, sq, mag;
      f = fs;
      forever begin
         freqs.push_back(f);
         nxt = f + fst;
         if (fst == 0 || nxt > fe || nxt > FMAX) break;
         f = nxt;
      end
      sn = (s == 0) ? 1 : s;
      mn = (m == 0) ? 1 : m;

      f_start    = FREQ_W'(fs);
      f_stop     = FREQ_W'(fe);
      f_step     = FREQ_W'(fst);
      settle_cyc = CNT_W'(s);
      meas_cyc   = CNT_W'(m);
      start = 1'b1;
      tick();
      start = 1'b0;
      // Later changes to the configuration inputs must not affect this sweep.
      f_start    = FREQ_W'($urandom);
      f_stop     = FREQ_W'($urandom);
      f_step     = FREQ_W'($urandom);
      settle_cyc = CNT_W'($urandom);
      meas_cyc   = CNT_W'($urandom);

      for (int p = 0; p < freqs.size(); p++) begin
         chk("ctrl_pulse", ctrl, 1);
         chk("freq", freq, freqs[p]);
         chk("busy", busy, 1);
         chk("valid_low", res_valid, 0);
         for (int k = 0; k < sn; k++) begin
            i_in  = DATA_W'($urandom);
            q_in  = DATA_W'($urandom);
            start = ($urandom_range(0, 2) == 0);
            tick();
            start = 1'b0;
            if (k == 0) chk("ctrl_one_cycle", ctrl, 0);
         end
         if (p == abort_pt) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_valid", res_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_freq", freq, freqs[p]);
            for (int k = 0; k < mn + 3; k++) begin
               tick();
               chk("abort_no_result", res_valid, 0);
               chk("abort_idle_busy", busy, 0);
            end
            return;
         end
         si = 0;
         sq = 0;
         for (int k = 0; k < mn; k++) begin
            if (cst) begin
               i_in = 10'sd5;
               q_in = -10'sd3;
            end else begin
               i_in = DATA_W'($urandom);
               q_in = DATA_W'($urandom);
            end
            si += longint'(i_in);
            sq += longint'(q_in);
            tick();
         end
`ifdef FREQ_SWEEP_MAG_EN
         mag = abs64(si) + abs64(sq);
`else
         mag = 0;
`endif
         chk("res_valid", res_valid, 1);
         chk("res_freq", res_freq, freqs[p]);
         chk("res_i", res_i, si);
         chk("res_q", res_q, sq);
         chk("res_mag", res_mag, mag);
         ns = (stall < 0) ? $urandom_range(0, 4) : stall;
         for (int k = 0; k < ns; k++) begin
            tick();
            chk("stall_valid", res_valid, 1);
            chk("stall_res_i", res_i, si);
            chk("stall_res_q", res_q, sq);
            chk("stall_res_freq", res_freq, freqs[p]);
            chk("stall_res_mag", res_mag, mag);
            chk("stall_freq", freq, freqs[p]);
            chk("stall_ctrl", ctrl, 0);
         end
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
         if (p == freqs.size() - 1) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_valid", res_valid, 0);
            chk("done_ctrl", ctrl, 0);
            tick();
            chk("done_one_cycle", done, 0);
         end
      end
   endtask

   initial begin
      int fs, fe, fst, ap;
      rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      f_start = '0; f_stop = '0; f_step = '0; settle_cyc = '0; meas_cyc = '0;
      i_in = '0; q_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_freq", freq, 0);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_res_i", res_i, 0);
      chk("rst_res_mag", res_mag, 0);

      // Basic three-point sweep with constant I/Q input.
      run_sweep(10, 30, 10, 4, 8, 0, 1'b1, -1);
      // Long backpressure at every point.
      run_sweep(100, 300, 100, 2, 3, 20, 1'b0, -1);
      // A step past the top of the range ends the sweep.
      run_sweep(16380, 16383, 10, 1, 2, -1, 1'b0, -1);
      // Zero step, with zero dwell lengths.
      run_sweep(50, 1000, 0, 0, 0, -1, 1'b0, -1);
      // Start above stop.
      run_sweep(500, 100, 7, 1, 1, -1, 1'b0, -1);
      // Abort during the second measurement, then a normal sweep.
      run_sweep(200, 600, 200, 3, 4, -1, 1'b0, 1);
      tick();
      run_sweep(200, 600, 200, 3, 4, -1, 1'b0, -1);

      // Reset in the middle of SETTLE.
      f_start = 14'd100; f_stop = 14'd900; f_step = 14'd100;
      settle_cyc = 16'd6; meas_cyc = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("srst_freq", freq, 0);
      chk("srst_ctrl", ctrl, 0);
      chk("srst_busy", busy, 0);
      chk("srst_done", done, 0);
      chk("srst_valid", res_valid, 0);
      chk("srst_res_freq", res_freq, 0);
      chk("srst_res_i", res_i, 0);
      chk("srst_res_q", res_q, 0);
      chk("srst_res_mag", res_mag, 0);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("srst_no_result", res_valid, 0);
      end
      // Reset wins over a simultaneous start.
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      chk("rst_over_start_busy", busy, 0);
      chk("rst_over_start_ctrl", ctrl, 0);
      tick();
      run_sweep(1000, 1200, 100, 2, 5, -1, 1'b0, -1);

      // Randomized sweeps.
      for (int n = 0; n < 30; n++) begin
         fs  = $urandom_range(0, FMAX);
         fst = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3000);
         fe  = fs + $urandom_range(0, 4 * (fst + 1));
         if ($urandom_range(0, 5) == 0) fe = $urandom_range(0, FMAX);
         if (fe > FMAX) fe = FMAX;
         ap  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
         run_sweep(fs, fe, fst, $urandom_range(0, 5), $urandom_range(0, 6),
                   -1, 1'b0, ap);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Overall time bound.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end
endmodule
